wshb_arbiter: RTL and testbench
===============================

WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter DATA_BYTES, default 4, Wishbone data width in bytes (data width 8*DATA_BYTES).
REQ-002 Parameter ADR_W, default 32, Wishbone address width.
REQ-003 sys_clk  in  1  single system clock, 100 MHz; all logic on its rising edge.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 m0_cyc, m0_stb, m0_we  in  1 each  requests from master 0 (test-pattern writer).
REQ-006 m0_adr  in  ADR_W; m0_dat_ms  in  8*DATA_BYTES; m0_sel  in  DATA_BYTES; m0_cti  in  3; m0_bte  in  2.
REQ-007 m0_ack, m0_err, m0_rty  out  1 each; m0_dat_sm  out  8*DATA_BYTES  responses to master 0.
REQ-008 m1_* ports  same names, directions and widths as REQ-005..007  master 1 (video read stage).
REQ-009 s_cyc, s_stb, s_we  out  1 each; s_adr  out  ADR_W; s_dat_ms  out  8*DATA_BYTES; s_sel  out  DATA_BYTES; s_cti  out  3; s_bte  out  2  towards SDRAM slave.
REQ-010 s_ack, s_err, s_rty  in  1 each; s_dat_sm  in  8*DATA_BYTES  SDRAM responses.
REQ-011 gnt  out  2  one-hot current grant (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-012 FSM states IDLE, GNT_M0, GNT_M1; state and gnt registered; gnt equals state encoding.
REQ-013 IDLE: s_cyc = s_stb = s_we = 0, s_adr/s_dat_ms/s_sel/s_cti/s_bte = 0; both masters see ack/err/rty = 0.
REQ-014 IDLE, exactly one mx_cyc sampled high -> GNT_Mx next cycle (1-cycle arbitration latency).
REQ-015 IDLE, both cyc high -> round-robin: grant the master not granted most recently (last_gnt register, updated on each grant).
REQ-016 GNT_Mx: all s_* request outputs combinationally equal mx_* inputs; s_ack/s_err/s_rty routed to mx only; non-granted master sees ack/err/rty = 0.
REQ-017 m0_dat_sm and m1_dat_sm both equal s_dat_sm at all times (qualified only by ack).
REQ-018 No preemption: GNT_Mx held while mx_cyc is 1, regardless of the other master, including across bursts (cti 3'b010).
REQ-019 GNT_Mx with mx_cyc sampled 0: other master's cyc high -> GNT_other next cycle directly; else -> IDLE.
REQ-020 Granted master dropping cyc mid-burst ends its grant per REQ-019; no transaction state retained.
REQ-021 Slave response arriving in IDLE is discarded (no master sees it).

Reset
REQ-022 On sys_rst sampled high: state = IDLE, gnt = 2'b00, last_gnt = m1 (so m0 wins first tie); s_cyc/s_stb = 0 from the following cycle.
REQ-023 Reset mid-transaction aborts the grant immediately; no ack forwarded while state is IDLE.

Configuration
REQ-024 Macro WSHB_ARB_VGA_PRIO_EN: defined -> fixed priority, m1 wins every tie in IDLE and in the REQ-019 hand-over; last_gnt unused; not defined -> round-robin per REQ-015.
REQ-025 Non-preemption (REQ-018) holds in both configurations.

Verification
REQ-026 After reset, m0_cyc=m1_cyc=1 same cycle -> gnt=01 one cycle later, s_adr = m0_adr; m1_ack stays 0.
REQ-027 m0 does 4 single writes (adr 0x0,0x4,0x8,0xC), slave acks each -> m0_ack pulses 4 times, s_we=1, m1 never acked.
REQ-028 m0 granted, m1_cyc raised; m0 releases cyc at cycle T -> gnt=10 at T+1, no IDLE cycle.
REQ-029 Both masters requesting continuously, each holding cyc for 8 acks -> grants alternate 01,10,01,10 (macro undefined); with WSHB_ARB_VGA_PRIO_EN, tie from IDLE -> gnt=10.
REQ-030 sys_rst asserted while gnt=10 mid-burst -> gnt=00 and s_cyc=0 next cycle; s_ack during reset not seen on m1_ack.

Source files
------------

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two-master Wishbone arbiter in front of a single SDRAM slave.
// m0 is the test-pattern writer, m1 the video read stage.
// Build option: define WSHB_ARB_VGA_PRIO_EN to give m1 fixed priority on every
// tie (round-robin otherwise). A granted master is never preempted either way.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no owner; slave bus driven to zero, slave responses dropped
// GNT_M0  | m0 owns the slave bus until it drops cyc
// GNT_M1  | m1 owns the slave bus until it drops cyc
module wshb_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int ADR_W      = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  // master 0
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADR_W-1:0]        m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  // master 1
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADR_W-1:0]        m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  // slave
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADR_W-1:0]        s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  // current owner, one-hot
  output logic [1:0]              gnt
);

  // encoding doubles as the one-hot grant vector
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   tie_m1;

`ifndef WSHB_ARB_VGA_PRIO_EN
  logic last_m1_q, last_m1_d;

  // remember the most recent owner so the other master takes the next tie
  always_comb begin
    last_m1_d = last_m1_q;
    if (state_d == GNT_M0) begin
      last_m1_d = 1'b0;
    end else if (state_d == GNT_M1) begin
      last_m1_d = 1'b1;
    end
  end

  // last-owner register; reset as if m1 had just owned the bus so m0 wins first
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_m1_q <= 1'b1;
    end else begin
      last_m1_q <= last_m1_d;
    end
  end

  assign tie_m1 = ~last_m1_q;
`else
  assign tie_m1 = 1'b1;
`endif

  // next-state: arbitrate only from IDLE or when the owner lets go of cyc
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = tie_m1 ? GNT_M1 : GNT_M0;
        end else if (m0_cyc) begin
          state_d = GNT_M0;
        end else if (m1_cyc) begin
          state_d = GNT_M1;
        end
      end
      GNT_M0: begin
        if (!m0_cyc) begin
          state_d = m1_cyc ? GNT_M1 : IDLE;
        end
      end
      GNT_M1: begin
        if (!m1_cyc) begin
          state_d = m0_cyc ? GNT_M0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset drops any grant at once, even mid-burst
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign gnt = state_q;

  // read data needs no steering: each master qualifies it with its own ack
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // route the owner's request to the slave and the slave's response back to it
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    case (state_q)
      GNT_M0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_rty   = s_rty;
      end
      GNT_M1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_rty   = s_rty;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed scenarios plus a long randomized run, all checked
// every cycle against an ownership model of the arbiter.
module tb_wshb_arbiter;
  localparam int DB = 4;
  localparam int AW = 32;
  localparam int DW = 8 * DB;
`ifdef WSHB_ARB_VGA_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_rty;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_ms, m0_dat_sm;
  logic [DB-1:0] m0_sel;
  logic [2:0]    m0_cti;
  logic [1:0]    m0_bte;
  logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_rty;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_ms, m1_dat_sm;
  logic [DB-1:0] m1_sel;
  logic [2:0]    m1_cti;
  logic [1:0]    m1_bte;
  logic          s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_ms, s_dat_sm;
  logic [DB-1:0] s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic [1:0]    gnt;

  int errors = 0;
  int checks = 0;

  wshb_arbiter #(.DATA_BYTES(DB), .ADR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ownership model: -1 nobody, 0 m0, 1 m1
  int       own = -1;
  int       last_own = 1;
  bit       chk_en = 1'b0;
  logic [1:0] req;

  // owner keeps the bus while its cyc is high; otherwise the other requester
  // takes over, ties from idle go to m1 in priority mode, else to the master
  // that did not own the bus most recently
  always @(posedge sys_clk) begin
    req = {m1_cyc, m0_cyc};
    if (sys_rst) begin
      own = -1;
      last_own = 1;
      chk_en = 1'b1;
    end else begin
      if (own >= 0 && req[own]) begin
        own = own;
      end else if (own >= 0) begin
        own = req[1 - own] ? 1 - own : -1;
      end else if (req == 2'b11) begin
        own = PRIO ? 1 : 1 - last_own;
      end else if (req == 2'b01) begin
        own = 0;
      end else if (req == 2'b10) begin
        own = 1;
      end
      if (own >= 0) last_own = own;
    end
  end

  logic [1:0]  exp_gnt;
  logic [75:0] exp_bus;
  logic [5:0]  exp_rsp;

  // per-cycle comparison of every DUT output against the model's owner
  always @(negedge sys_clk) begin
    if (chk_en) begin
      exp_gnt = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      exp_bus = '0;
      exp_rsp = '0;
      if (own == 0) begin
        exp_bus = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte};
        exp_rsp = {s_ack, s_err, s_rty, 3'b000};
      end else if (own == 1) begin
        exp_bus = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte};
        exp_rsp = {3'b000, s_ack, s_err, s_rty};
      end
      chk("gnt", 128'(gnt), 128'(exp_gnt));
      chk("slave_req", 128'({s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}), 128'(exp_bus));
      chk("master_rsp", 128'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 128'(exp_rsp));
      chk("dat_sm", 128'({m0_dat_sm, m1_dat_sm}), 128'({s_dat_sm, s_dat_sm}));
    end
  end

  bit cnt_en = 1'b0;
  int n_ack0 = 0;
  int n_ack1 = 0;

  // ack pulse counters for the directed write sequence
  always @(negedge sys_clk) begin
    if (cnt_en) begin
      if (m0_ack) n_ack0++;
      if (m1_ack) n_ack1++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat_sm = '0;
  endtask

  task automatic do_reset();
    sys_rst = 1;
    tick();
    tick();
    sys_rst = 0;
  endtask

  logic [1:0] seq [4];
  logic [1:0] g, prev_g;
  logic       a0, a1, loser_ack;
  int         c0, c1, nseq;
  bit         idle_seen;

  initial begin
    idle_inputs();
    sys_rst = 1;
    tick();
    tick();

    // simultaneous request straight out of reset
    sys_rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1234_5670;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hABCD_0000;
    s_ack = 1;
    @(negedge sys_clk);
    chk("rst_gnt", 128'(gnt), 128'(2'b00));
    chk("rst_s_cyc", 128'(s_cyc), 128'(1'b0));
    chk("idle_ack_dropped", 128'({m0_ack, m1_ack}), 128'(2'b00));
    @(negedge sys_clk);
    loser_ack = PRIO ? m0_ack : m1_ack;
    chk("tie_gnt", 128'(gnt), PRIO ? 128'(2'b10) : 128'(2'b01));
    chk("tie_adr", 128'(s_adr), PRIO ? 128'(32'hABCD_0000) : 128'(32'h1234_5670));
    chk("tie_loser_ack", 128'(loser_ack), 128'(1'b0));

    // m0: four single writes while m1 waits
    idle_inputs();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_8000;
    n_ack0 = 0; n_ack1 = 0; cnt_en = 1;
    for (int i = 0; i < 4; i++) begin
      m0_adr = 32'(i * 4);
      m0_dat_ms = $urandom;
      s_ack = 1;
      @(negedge sys_clk);
      chk("wr_s_we", 128'(s_we), 128'(1'b1));
      chk("wr_s_adr", 128'(s_adr), 128'(32'(i * 4)));
      tick();
      s_ack = 0;
      tick();
    end
    cnt_en = 0;
    chk("wr_m0_acks", 128'(n_ack0), 128'(4));
    chk("wr_m1_acks", 128'(n_ack1), 128'(0));

    // m0 lets go: m1 takes over on the very next cycle
    m0_cyc = 0; m0_stb = 0;
    @(negedge sys_clk);
    chk("release_gnt", 128'(gnt), 128'(2'b01));
    @(negedge sys_clk);
    chk("handover_gnt", 128'(gnt), 128'(2'b10));
    chk("handover_adr", 128'(s_adr), 128'(32'h0000_8000));

    // reset in the middle of an m1 burst
    tick();
    m1_cti = 3'b010; s_ack = 1;
    tick();
    sys_rst = 1;
    @(negedge sys_clk);
    chk("burst_gnt", 128'(gnt), 128'(2'b10));
    @(negedge sys_clk);
    chk("abort_gnt", 128'(gnt), 128'(2'b00));
    chk("abort_s_cyc", 128'(s_cyc), 128'(1'b0));
    chk("abort_m1_ack", 128'(m1_ack), 128'(1'b0));

    // both masters busy, each holds the bus for 8 acks
    idle_inputs();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    c0 = 0; c1 = 0; nseq = 0; prev_g = 2'b00; idle_seen = 0;
    for (int k = 0; k < 4; k++) seq[k] = 2'b00;
    for (int n = 0; n < 200 && nseq < 4; n++) begin
      @(negedge sys_clk);
      a0 = m0_ack; a1 = m1_ack; g = gnt;
      if (g != prev_g && g != 2'b00) begin
        seq[nseq] = g;
        nseq++;
      end
      if (nseq > 0 && g == 2'b00) idle_seen = 1;
      prev_g = g;
      @(posedge sys_clk);
      #2;
      if (m0_cyc) begin
        if (a0) c0++;
        if (c0 == 8) begin m0_cyc = 0; c0 = 0; end
      end else begin
        m0_cyc = 1;
      end
      if (m1_cyc) begin
        if (a1) c1++;
        if (c1 == 8) begin m1_cyc = 0; c1 = 0; end
      end else begin
        m1_cyc = 1;
      end
    end
    chk("alt_count", 128'(nseq), 128'(4));
    chk("alt_seq", 128'({seq[0], seq[1], seq[2], seq[3]}), PRIO ? 128'(8'b10_01_10_01) : 128'(8'b01_10_01_10));
    chk("alt_no_idle", 128'(idle_seen), 128'(1'b0));

    // randomized traffic, occasional resets, slave responses at any time
    idle_inputs();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      tick();
      sys_rst = ($urandom_range(0, 99) == 0);
      if (m0_cyc) m0_cyc = ($urandom_range(0, 7) != 0);
      else        m0_cyc = ($urandom_range(0, 2) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(0, 7) != 0);
      else        m1_cyc = ($urandom_range(0, 2) == 0);
      m0_stb = 1'($urandom_range(0, 1)); m0_we = 1'($urandom_range(0, 1));
      m0_adr = $urandom; m0_dat_ms = $urandom; m0_sel = 4'($urandom);
      m0_cti = 3'($urandom); m0_bte = 2'($urandom);
      m1_stb = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
      m1_adr = $urandom; m1_dat_ms = $urandom; m1_sel = 4'($urandom);
      m1_cti = 3'($urandom); m1_bte = 2'($urandom);
      s_ack = 1'($urandom_range(0, 1)); s_err = ($urandom_range(0, 7) == 0);
      s_rty = ($urandom_range(0, 7) == 0); s_dat_sm = $urandom;
    end
    tick();
    sys_rst = 0;
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
